// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : Five-button synchronizer/debouncer with one-hot touch handshake,
//            merged-press counter and free-running tick strobe.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       b4,
    input  logic       b5,
    input  logic       touch_ack,
    output logic       touch_valid,
    output logic [4:0] touch,
    output logic [4:0] db,
    output logic       tick,
    output logic [7:0] drop_cnt
);

    localparam int c_DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam int c_TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_CYCLES - 1);

    logic [4:0]      w_btn;
    logic [4:0]      r_sync1;
    logic [4:0]      r_sync2;
    logic [4:0]      r_db;
    logic [4:0]      r_db_q;
    logic [c_DW-1:0] r_cnt [5];
    logic [4:0]      r_pend;
    logic [4:0]      r_touch;
    logic            r_tv;
    logic [7:0]      r_drop;
    logic [4:0]      w_rise;
    logic            w_load;
    logic [4:0]      w_pick;
    logic [4:0]      w_drop;
    logic [4:0]      w_pend_nxt;
    logic [8:0]      w_drop_sum;
    logic [7:0]      w_drop_nxt;
    logic            r_tick_run;
    logic [c_TW-1:0] r_tick_cnt;
    logic [c_TW-1:0] w_tick_cnt_nxt;
    logic            r_tick;

    assign w_btn = {b5, b4, b3, b2, b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db <= '0;
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_DB_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise     = r_db & ~r_db_q;
    assign w_load     = ~r_tv | touch_ack;
    // Isolate the lowest set pending bit (two's-complement trick).
    assign w_pick     = w_load ? (r_pend & (~r_pend + 5'd1)) : 5'd0;
    // A rise on a bit being handed off this cycle re-arms it instead of merging.
    assign w_drop     = w_rise & r_pend & ~w_pick;
    assign w_pend_nxt = (r_pend & ~w_pick) | w_rise;
    assign w_drop_sum = {1'b0, r_drop} + 9'($countones(w_drop));
    assign w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_q  <= '0;
            r_pend  <= '0;
            r_touch <= '0;
            r_tv    <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_db_q <= r_db;
            r_pend <= w_pend_nxt;
            r_drop <= w_drop_nxt;
            if (w_load) begin
                r_touch <= w_pick;
                r_tv    <= |r_pend;
            end
        end
    end

    // The first edge after reset only arms the counter, so the counter sits at
    // TICK_CYCLES-1 (and tick is high) TICK_CYCLES edges after release.
    always_comb begin
        w_tick_cnt_nxt = r_tick_cnt;
        if (!r_tick_run) begin
            w_tick_cnt_nxt = '0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            w_tick_cnt_nxt = '0;
        end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_run <= 1'b0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_run <= 1'b1;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tick     <= (w_tick_cnt_nxt == c_TICK_LAST);
        end
    end

    assign db          = r_db;
    assign touch       = r_touch;
    assign touch_valid = r_tv;
    assign tick        = r_tick;
    assign drop_cnt    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Directed + randomized bench for btn_conditioner against a
//            window-based behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int c_D = 4;
    localparam int c_T = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = 5'd0;
    logic       touch_ack = 1'b0;
    logic       touch_valid;
    logic [4:0] touch;
    logic [4:0] db;
    logic       tick;
    logic [7:0] drop_cnt;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model state
    bit         hist [5][$];
    logic [4:0] m_db, m_dbq, m_pend, m_touch;
    bit         m_tv, m_tick;
    int         m_drop, ecount;
    int         rem [5];

    btn_conditioner #(
        .DEBOUNCE_CYCLES(c_D),
        .TICK_CYCLES    (c_T)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .b1         (btn[0]),
        .b2         (btn[1]),
        .b3         (btn[2]),
        .b4         (btn[3]),
        .b5         (btn[4]),
        .touch_ack  (touch_ack),
        .touch_valid(touch_valid),
        .touch      (touch),
        .db         (db),
        .tick       (tick),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_db = '0; m_dbq = '0; m_pend = '0; m_touch = '0;
        m_tv = 1'b0; m_tick = 1'b0; m_drop = 0; ecount = 0;
        for (int i = 0; i < 5; i++) begin
            hist[i].delete();
            for (int j = 0; j <= c_D; j++) hist[i].push_back(1'b0);
        end
    endtask

    // One clock edge: a level flips when the last c_D synchronized samples
    // (raw input delayed two edges) all disagree with it.
    task automatic model_edge();
        logic [4:0] nd;
        int  pick;
        bit  load, all_diff, rise, keep;
        pick = -1;
        for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= c_D; j++)
                if (hist[i][j] == m_db[i]) all_diff = 1'b0;
            nd[i] = all_diff ? ~m_db[i] : m_db[i];
        end
        load = !m_tv || touch_ack;
        if (load)
            for (int i = 0; i < 5; i++)
                if (m_pend[i] && pick < 0) pick = i;
        for (int i = 0; i < 5; i++) begin
            rise = m_db[i] && !m_dbq[i];
            keep = m_pend[i] && (i != pick);
            if (rise && keep && m_drop < 255) m_drop++;
            m_pend[i] = keep || rise;
        end
        if (load) begin
            m_tv    = (pick >= 0);
            m_touch = (pick >= 0) ? 5'(1 << pick) : 5'd0;
        end
        ecount++;
        m_tick = ((ecount % c_T) == 0);
        for (int i = 0; i < 5; i++) begin
            hist[i].push_front(btn[i]);
            void'(hist[i].pop_back());
        end
        m_dbq = m_db;
        m_db  = nd;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("db",       8'(db),          8'(m_db));
        chk("valid",    8'(touch_valid), 8'(m_tv));
        chk("touch",    8'(touch),       8'(m_touch));
        chk("drop_cnt", drop_cnt,        8'(m_drop));
        chk("tick",     8'(tick),        8'(m_tick));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk({tag, "_db"},    8'(db),          8'd0);
        chk({tag, "_valid"}, 8'(touch_valid), 8'd0);
        chk({tag, "_touch"}, 8'(touch),       8'd0);
        chk({tag, "_tick"},  8'(tick),        8'd0);
        chk({tag, "_drop"},  drop_cnt,        8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset("rst0");

        // Held b3: debounced at cycle 6, presented at cycle 8, held until ack.
        btn[2] = 1'b1;
        repeat (5) step();
        chk("b3_db_c5", 8'(db), 8'h00);
        step();
        chk("b3_db_c6", 8'(db), 8'h04);
        step();
        chk("b3_valid_c7", 8'(touch_valid), 8'd0);
        step();
        chk("b3_valid_c8", 8'(touch_valid), 8'd1);
        chk("b3_touch_c8", 8'(touch), 8'h04);
        for (int k = 9; k <= 35; k++) begin
            step();
            chk("tick_seq", 8'(tick), 8'((k % 10) == 0));
            if (k == 20) begin
                chk("b3_held_touch", 8'(touch), 8'h04);
                btn[2]    = 1'b0;
                touch_ack = 1'b1;
            end
            if (k == 21) begin
                touch_ack = 1'b0;
                chk("b3_after_ack", 8'(touch_valid), 8'd0);
            end
        end

        // Three-cycle glitch on b2 is rejected.
        btn[1] = 1'b1;
        repeat (3) step();
        btn[1] = 1'b0;
        repeat (8) step();
        chk("glitch_db",    8'(db),          8'd0);
        chk("glitch_valid", 8'(touch_valid), 8'd0);
        chk("glitch_drop",  drop_cnt,        8'd0);

        // b1 and b5 together, ack tied high: back-to-back presentation.
        touch_ack = 1'b1;
        btn[0] = 1'b1;
        btn[4] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 8)  chk("dual_first",  8'(touch), 8'h01);
            if (k == 9)  chk("dual_second", 8'(touch), 8'h10);
            if (k == 10) chk("dual_empty",  8'(touch_valid), 8'd0);
        end
        btn = 5'd0;
        touch_ack = 1'b0;
        repeat (8) step();

        // Three presses of b4 without ack: one shown, one pending, one merged.
        for (int p = 0; p < 3; p++) begin
            btn[3] = 1'b1;
            repeat (7) step();
            if (p < 2) begin
                btn[3] = 1'b0;
                repeat (7) step();
            end
        end
        chk("merge_touch", 8'(touch), 8'h08);
        chk("merge_valid", 8'(touch_valid), 8'd1);
        chk("merge_drop",  drop_cnt, 8'd1);

        // Reset mid-handshake with b4 still held: only a fresh debounce counts.
        do_reset("rst_mid");
        repeat (7) step();
        chk("rst_held_c7", 8'(touch_valid), 8'd0);
        step();
        chk("rst_held_c8", 8'(touch), 8'h08);
        btn = 5'd0;
        touch_ack = 1'b1;
        repeat (3) step();
        touch_ack = 1'b0;

        // Drive all buttons hard with no ack until the merge counter saturates.
        for (int c = 0; c < 800; c++) begin
            btn = ((c % 12) < 6) ? 5'h1F : 5'h00;
            step();
        end
        chk("drop_saturated", drop_cnt, 8'hFF);

        // Randomized levels (including sub-debounce glitches) and random ack.
        do_reset("rst_rand");
        btn = 5'd0;
        for (int i = 0; i < 5; i++) rem[i] = $urandom_range(1, 12);
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset("rst_rand_mid");
            for (int i = 0; i < 5; i++) begin
                if (rem[i] == 0) begin
                    btn[i] = ~btn[i];
                    rem[i] = $urandom_range(1, 12);
                end else begin
                    rem[i]--;
                end
            end
            touch_ack = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
